// File: rtl/alu_op_sequencer_if.sv
// Command/result handshake bundle between a command producer and alu_op_sequencer.
// master = producer/consumer side, slave = the sequencer.
interface alu_op_sequencer_if #(
    parameter int unsigned TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [63:0]      cmd_a;
    logic [63:0]      cmd_b;
    logic [3:0]       cmd_sel;
    logic [TAG_W-1:0] cmd_tag;

    logic             res_valid;
    logic             res_ready;
    logic [63:0]      res_data;
    logic [3:0]       res_flags;
    logic [TAG_W-1:0] res_tag;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_tag, res_ready,
        input  cmd_ready, res_valid, res_data, res_flags, res_tag
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_tag, res_ready,
        output cmd_ready, res_valid, res_data, res_flags, res_tag
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// FIFO-buffered command front-end for alu_64bit: one op at a time, result + {C,Z,S,V} + tag.
// Optional statistics counters are enabled with `define ALU_SEQ_STATS_EN.
module alu_op_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    alu_op_sequencer_if.slave        cmd_res,
    output logic                     alu_enable,
    output logic [63:0]              alu_a,
    output logic [63:0]              alu_b,
    output logic [3:0]               alu_sel,
    input  logic [63:0]              alu_out,
    input  logic                     alu_carryout,
    input  logic                     alu_zero,
    input  logic                     alu_sign,
    input  logic                     alu_overflow,
    output logic                     busy
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [31:0]              op_count,
    output logic [15:0]              divzero_count
`endif
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [63:0]      a;
        logic [63:0]      b;
        logic [3:0]       sel;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic [2:0] {IDLE, EXEC1, EXEC2, CAPT, DONE} state_t;

    cmd_t             mem [DEPTH];
    cmd_t             head;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    state_t           state;
    logic [TAG_W-1:0] tag_q;

    logic fifo_empty;
    logic fifo_full;
    logic do_push;
    logic do_pop;
    logic res_hs;

    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == FULL_CNT);
        do_push    = cmd_res.cmd_valid & ~fifo_full;
        res_hs     = cmd_res.res_valid & cmd_res.res_ready;
        do_pop     = ~fifo_empty & ((state == IDLE) | ((state == DONE) & res_hs));
        head       = mem[rd_ptr];
    end

    assign cmd_res.cmd_ready = ~fifo_full;
    assign busy              = (state != IDLE) | ~fifo_empty;

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= '{a: cmd_res.cmd_a, b: cmd_res.cmd_b,
                             sel: cmd_res.cmd_sel, tag: cmd_res.cmd_tag};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Enable is held through EXEC1 and EXEC2 so Zero/Sign catch up with out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            alu_enable        <= 1'b0;
            alu_a             <= '0;
            alu_b             <= '0;
            alu_sel           <= '0;
            tag_q             <= '0;
            cmd_res.res_valid <= 1'b0;
            cmd_res.res_data  <= '0;
            cmd_res.res_flags <= '0;
            cmd_res.res_tag   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (do_pop) begin
                        alu_a      <= head.a;
                        alu_b      <= head.b;
                        alu_sel    <= head.sel;
                        tag_q      <= head.tag;
                        alu_enable <= 1'b1;
                        state      <= EXEC1;
                    end
                end
                EXEC1: begin
                    state <= EXEC2;
                end
                EXEC2: begin
                    alu_enable <= 1'b0;
                    state      <= CAPT;
                end
                CAPT: begin
                    cmd_res.res_data  <= alu_out;
                    cmd_res.res_flags <= {alu_carryout, alu_zero, alu_sign, alu_overflow};
                    cmd_res.res_tag   <= tag_q;
                    cmd_res.res_valid <= 1'b1;
                    state             <= DONE;
                end
                DONE: begin
                    if (res_hs) begin
                        cmd_res.res_valid <= 1'b0;
                        if (do_pop) begin
                            alu_a      <= head.a;
                            alu_b      <= head.b;
                            alu_sel    <= head.sel;
                            tag_q      <= head.tag;
                            alu_enable <= 1'b1;
                            state      <= EXEC1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    alu_enable <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_STATS_EN
    // alu_sel/alu_b still describe the completing op at the handshake edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count      <= '0;
            divzero_count <= '0;
        end else if (res_hs) begin
            op_count <= op_count + 1'b1;
            if (alu_sel == 4'b1110 && alu_b == '0 && divzero_count != 16'hFFFF) begin
                divzero_count <= divzero_count + 1'b1;
            end
        end
    end
`endif

endmodule
